// File: rtl/vga_pkg.sv
// Display and framebuffer constants shared by the int_vga timing path and the draw side.
`default_nettype none

package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int FB_W     = 320;
  localparam int FB_H     = 240;
  localparam int FB_WORDS = FB_W * FB_H;
  localparam int ADDR_W   = 17;
  localparam int CNT_W    = 10;
  localparam int SCAN_LAT = 3;

  typedef logic [11:0] pixel_t;

  typedef enum logic [1:0] {
    SLOT_IDLE  = 2'd0,
    SLOT_READ  = 2'd1,
    SLOT_WRITE = 2'd2,
    SLOT_DROP  = 2'd3
  } slot_e;

endpackage

`default_nettype wire

// File: rtl/fb_addr_gen.sv
// Framebuffer word coordinate (x,y) to linear address: y*320 + x, built from shifts and adds.
`default_nettype none

module fb_addr_gen
  import vga_pkg::*;
(
  input  logic [CNT_W-2:0]  x_i,
  input  logic [CNT_W-2:0]  y_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;

  assign row    = ADDR_W'(y_i);
  assign col    = ADDR_W'(x_i);
  assign addr_o = (row << 8) + (row << 6) + col;

endmodule

`default_nettype wire

// File: rtl/fb_scan_arbiter.sv
// Time-slices one single-port framebuffer RAM between 2x-doubled VGA scan-out and a draw-side writer.
`default_nettype none

module fb_scan_arbiter
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  h_count,
  input  logic [CNT_W-1:0]  v_count,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [11:0]       wr_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [11:0]       ram_wdata,
  input  logic [11:0]       ram_rdata,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              wr_err,
  output logic              frame_start
);

  logic              active;
  logic              rd_slot;
  logic              wr_in_range;
  logic [ADDR_W-1:0] rd_addr;
  slot_e             slot;

  logic [ADDR_W-1:0] ram_addr_q,  ram_addr_d;
  logic              ram_we_q,    ram_we_d;
  logic [11:0]       ram_wdata_q, ram_wdata_d;
  logic              wr_err_q,    wr_err_d;
  logic              frame_start_q;
  pixel_t            rgb_q,       rgb_d;
  logic [SCAN_LAT-2:0] act_q;
  logic [SCAN_LAT-2:0] rd_q;

  assign active      = (h_count < CNT_W'(H_ACTIVE)) && (v_count < CNT_W'(V_ACTIVE));
  assign rd_slot     = active && !h_count[0];
  assign wr_ready    = !reset && !rd_slot;
  assign wr_in_range = wr_addr < ADDR_W'(FB_WORDS);

  fb_addr_gen u_addr_gen (
    .x_i    (h_count[CNT_W-1:1]),
    .y_i    (v_count[CNT_W-1:1]),
    .addr_o (rd_addr)
  );

  always_comb begin
    slot = SLOT_IDLE;
    if (rd_slot) begin
      slot = SLOT_READ;
    end else if (wr_valid) begin
      slot = wr_in_range ? SLOT_WRITE : SLOT_DROP;
    end
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    wr_err_d    = wr_err_q;
    case (slot)
      SLOT_READ: begin
        ram_addr_d = rd_addr;
      end
      SLOT_WRITE: begin
        ram_addr_d  = wr_addr;
        ram_wdata_d = wr_data;
        ram_we_d    = 1'b1;
      end
      SLOT_DROP: begin
        ram_addr_d  = wr_addr;
        ram_wdata_d = wr_data;
        wr_err_d    = 1'b1;
      end
      default: ;
    endcase
  end

  // Capture on the cycle read data returns; hold for the doubled pixel; blank outside the active area.
  always_comb begin
    rgb_d = rgb_q;
    if (!act_q[SCAN_LAT-2]) begin
      rgb_d = '0;
    end else if (rd_q[SCAN_LAT-2]) begin
      rgb_d = ram_rdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      wr_err_q      <= 1'b0;
      frame_start_q <= 1'b0;
      rgb_q         <= '0;
      act_q         <= '0;
      rd_q          <= '0;
    end else begin
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      wr_err_q      <= wr_err_d;
      frame_start_q <= (h_count == '0) && (v_count == '0);
      rgb_q         <= rgb_d;
      act_q         <= {act_q[SCAN_LAT-3:0], active};
      rd_q          <= {rd_q[SCAN_LAT-3:0], rd_slot};
    end
  end

  assign ram_addr    = ram_addr_q;
  assign ram_we      = ram_we_q;
  assign ram_wdata   = ram_wdata_q;
  assign wr_err      = wr_err_q;
  assign frame_start = frame_start_q;
  assign red         = rgb_q[11:8];
  assign green       = rgb_q[7:4];
  assign blue        = rgb_q[3:0];

endmodule

`default_nettype wire
